// File: rtl/dec_rr_arbiter.sv
// Four-way round-robin arbiter driving a 2-to-4 decoder (A1/A0/EN) with bounded grant hold time.
// Optional macro ARB_DEADTIME_EN inserts a one-cycle EN=0 gap between any two grants.
module dec_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic       A0,
  output logic       A1,
  output logic       EN,
  output logic [3:0] gnt,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
`ifdef ARB_DEADTIME_EN
  localparam logic [1:0] S_GAP   = 2'd2;
`endif
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_MAX);

  logic [1:0]       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       others;
  logic             timeout;
  logic             release_now;
  logic             grant_d;

  // First asserted request in the order last+1, last+2, last+3, last wins.
  // Later loop iterations overwrite earlier ones, so the loop runs lowest priority first.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] c;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      c = last + 2'(k);
      if (r[c]) rr_pick = c;
    end
  endfunction

  // While granting, gnt is one-hot of last_q, so masking it leaves the competing requests.
  assign others      = req & ~gnt;
  assign timeout     = (cnt_q == HOLD);
  assign release_now = !req[last_q] || (timeout && (|others));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_GRANT: begin
        if (release_now) begin
`ifdef ARB_DEADTIME_EN
          state_d = S_GAP;
          cnt_d   = '0;
`else
          if (|others) begin
            last_d = rr_pick(others, last_q);
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
`endif
        end else if (!timeout) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // IDLE, and the one-cycle GAP, arbitrate on the same edge.
        state_d = S_IDLE;
        if (|req) begin
          state_d = S_GRANT;
          last_d  = rr_pick(req, last_q);
          cnt_d   = CNT_W'(1);
        end
      end
    endcase
  end

  assign grant_d = (state_d == S_GRANT);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= 2'd3;
      cnt_q    <= '0;
      EN       <= 1'b0;
      gnt      <= 4'b0000;
      {A1, A0} <= 2'b00;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      EN       <= grant_d;
      gnt      <= grant_d ? (4'b0001 << last_d) : 4'b0000;
      {A1, A0} <= grant_d ? last_d : 2'b00;
      busy     <= grant_d;
    end
  end

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Self-checking bench for dec_rr_arbiter (default build, HOLD_MAX=8): vector table plus hold-time sequences.
module tb_dec_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       A0, A1, EN, busy;
  logic [3:0] gnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];

  dec_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .A0  (A0),
    .A1  (A1),
    .EN  (EN),
    .gnt (gnt),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected grant, compare just after the edge.
  task automatic cycle(input logic r, input logic [3:0] q, input logic [3:0] g);
    logic [3:0] e;
    logic [1:0] sel;
    rst = r;
    req = q;
    exp_q.push_back(g);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: empty queue at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("gnt", {4'h0, gnt}, {4'h0, e});
      check("EN", {7'h0, EN}, {7'h0, (e != 4'h0)});
      check("busy", {7'h0, busy}, {7'h0, (e != 4'h0)});
      case (e)
        4'b0010: sel = 2'd1;
        4'b0100: sel = 2'd2;
        4'b1000: sel = 2'd3;
        default: sel = 2'd0;
      endcase
      if (e != 4'h0 || r) check("sel", {6'h0, A1, A0}, {6'h0, sel});
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'h0;

    vecs.push_back('{1'b1, 4'b0000, 4'b0000});
    for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100});  // first grant after reset
    vecs.push_back('{1'b0, 4'b0100, 4'b0100});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000});  // drop -> idle
    vecs.push_back('{1'b0, 4'b0010, 4'b0010});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100});  // req1 drops as req2 rises
    vecs.push_back('{1'b0, 4'b0100, 4'b0100});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001});  // pointer at 2: search 3,0,...
    vecs.push_back('{1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100});
    vecs.push_back('{1'b1, 4'b1111, 4'b0000});  // reset mid-grant
    vecs.push_back('{1'b0, 4'b1111, 4'b0001});  // pointer back to 3
    vecs.push_back('{1'b1, 4'b0000, 4'b0000});

    foreach (vecs[i]) cycle(vecs[i].rst, vecs[i].req, vecs[i].gnt);

    // All four requesting: rotate 0,1,2,3,0 with 8 cycles per grant.
    cycle(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 40; k++) cycle(1'b0, 4'b1111, 4'b0001 << ((k / 8) % 4));

    // Lone requester beyond the hold limit keeps its grant.
    cycle(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 20; k++) cycle(1'b0, 4'b0010, 4'b0010);
    // Saturated counter and a new requester: immediate handover, then a full hold period.
    for (int k = 0; k < 8; k++) cycle(1'b0, 4'b1010, 4'b1000);
    cycle(1'b0, 4'b1010, 4'b0010);
    cycle(1'b0, 4'b1010, 4'b0010);
    cycle(1'b0, 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_rr_arbiter.md
Name: dec_rr_arbiter

Overview:
Four-way round-robin arbiter that shares the 2-to-4 decoder between four requesters. It drives the decoder's select lines A1/A0 and its enable EN, and mirrors the decoded one-hot grant on gnt. Each grant has a bounded hold time, so no requester can monopolise the decoder.

Parameters:
HOLD_MAX, 8, maximum cycles one grant is kept while another requester is pending; legal range 1..2^CNT_W-1
CNT_W, 4, width of the hold counter

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request vector; req[i] held high while requester i wants the decoder
A0  output  1  decoder select LSB (grant index bit 0)
A1  output  1  decoder select MSB (grant index bit 1)
EN  output  1  decoder enable; high only while a grant is active
gnt  output  4  one-hot grant; equals decoder Y: EN ? (1 << {A1,A0}) : 0
busy  output  1  high in GRANT state

Behaviour:
- All outputs are registered. Request-to-grant latency is 1 cycle: req is sampled at edge N, and the grant is visible after edge N.
- Reset (sync, active-high): state=IDLE, A1=A0=0, EN=0, gnt=0, busy=0, hold counter=0, last-grant pointer=3, so req[0] has first priority after reset.
- Reset asserted mid-grant clears everything at the next edge. No partial grant survives.
- Arbitration search order: last+1, last+2, last+3, last (mod 4). The first asserted req wins, and the pointer is updated to the winner.
- States:
  - IDLE: EN=0, gnt=0. If any req is high, go to GRANT with the arbitrated index and hold counter=1. Otherwise stay in IDLE.
  - GRANT: EN=1, {A1,A0}=idx, gnt=one-hot(idx), busy=1. Hold counter increments each cycle and saturates at HOLD_MAX.
  - GAP: exists only with the optional feature. EN=0, gnt=0, lasts exactly 1 cycle, then behaves as IDLE (arbitrates the same edge).
- Release conditions, evaluated each GRANT cycle:
  - (a) req[idx]==0.
  - (b) counter==HOLD_MAX and some other req[j], j!=idx, is high.
- On release without GAP:
  - If another request is pending, re-arbitrate at the same edge, excluding idx in case (b).
  - The new grant appears the next cycle, with EN staying high and A1/A0/gnt switching in one cycle, and counter=1.
  - If no request is pending, go to IDLE.
- Timeout with no other requester pending: the grant is kept, the counter stays saturated, and there is no release.
- Simultaneous events:
  - req[idx] dropping in the same cycle another req rises: the new requester is granted next cycle.
  - All four req held high: grants rotate 0,1,2,3,0... with each grant lasting exactly HOLD_MAX cycles.
- gnt is always exactly one-hot or zero. gnt!=0 if and only if EN=1.

Optional Feature:
Macro ARB_DEADTIME_EN.
- Defined: every release goes through GAP. EN=0 for exactly one cycle between any two grants, so there is never a direct switch of A1/A0 while EN=1.
- Undefined: the GAP state is not compiled. Back-to-back handover happens with no idle cycle, as described above.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> EN=0, gnt=0, A1=A0=0, busy=0 throughout.
- After reset, req=4'b0100 at edge N -> after edge N: EN=1, A1=1, A0=0, gnt=4'b0100. Drop req at edge M -> after edge M: EN=0, gnt=0.
- HOLD_MAX=8, req=4'b1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001, each lasting 8 cycles. Without the macro EN stays high continuously; with ARB_DEADTIME_EN a 1-cycle EN=0 gap appears between grants.
- req=4'b0010 alone held 20 cycles -> gnt=4'b0010 all 20 cycles and the counter saturates at 8. Raise req[3] at cycle 20 -> gnt=4'b1000 on the next cycle (or after a 1-cycle gap with the macro).
- Assert rst for 1 cycle while gnt=4'b0100 -> after that edge all outputs are 0. With req=4'b1111 still high, the next grant is 4'b0001 (pointer reset to 3).
- req[1] drops in the same cycle req[2] rises, current grant is 1 -> next cycle gnt=4'b0100 and counter=1.
